// File: rtl/branch_sequencer_if.sv
// Branch sequencer bus: decoded branch operands toward the sequencer and
// the PC update, CON flag and completion status coming back.
interface branch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic              start;
    logic              abort;
    logic [31:0]       ir;
    logic [31:0]       ra_value;
    logic [31:0]       pc;
    logic              con;
    logic              pc_load;
    logic [31:0]       pc_next;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  taken_count;

    // start is a single-cycle request that is only accepted while busy is low;
    // there is no back-pressure beyond that, and pc_next is valid only with pc_load.
    modport master (
        output start, abort, ir, ra_value, pc,
        input  con, pc_load, pc_next, busy, done, taken_count
    );

    modport slave (
        input  start, abort, ir, ra_value, pc,
        output con, pc_load, pc_next, busy, done, taken_count
    );
endinterface

// File: rtl/branch_sequencer.sv
// Conditional branch sequencer: captures operands, evaluates the branch
// condition into CON, computes PC + sign-extended displacement and commits it.
module branch_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     clear,
    branch_sequencer_if.slave        bus,
    output logic [1:0]               fsm_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RESOLVE = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t            state;
    logic [20:0]       lat_ir;
    logic [31:0]       lat_ra;
    logic [31:0]       lat_pc;
    logic              con_q;
    logic              pc_load_q;
    logic [31:0]       pc_next_q;
    logic              done_q;
    logic [CNT_W-1:0]  count_q;

    logic              cond;
    logic [31:0]       target;

    always_comb begin
        cond = 1'b0;
        case (lat_ir[20:19])
            2'd0: cond = (lat_ra == 32'd0);
            2'd1: cond = (lat_ra != 32'd0);
            2'd2: cond = ~lat_ra[31];
            2'd3: cond = lat_ra[31];
            default: cond = 1'b0;
        endcase
    end

    // 32-bit add wraps naturally; no overflow is reported
    assign target = lat_pc + {{13{lat_ir[18]}}, lat_ir[18:0]};

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            lat_ir    <= '0;
            lat_ra    <= '0;
            lat_pc    <= '0;
            con_q     <= 1'b0;
            pc_load_q <= 1'b0;
            pc_next_q <= '0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            pc_load_q <= 1'b0;
            done_q    <= 1'b0;
            if (bus.abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            lat_ir <= bus.ir[20:0];
                            lat_ra <= bus.ra_value;
                            lat_pc <= bus.pc;
                            state  <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        con_q <= cond;
                        state <= RESOLVE;
                    end
                    RESOLVE: begin
                        pc_load_q <= con_q;
                        done_q    <= 1'b1;
                        // pc_next only moves for taken branches so it holds otherwise
                        if (con_q) begin
                            pc_next_q <= target;
                        end
                        state <= COMMIT;
                    end
                    COMMIT: begin
                        if (pc_load_q && !(&count_q)) begin
                            count_q <= count_q + 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.con         = con_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_next     = pc_next_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.taken_count = count_q;
    assign fsm_state       = state;
endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: per-cycle comparison against a
// transaction-level model plus hand-computed checkpoints.
module tb_branch_sequencer;
    localparam int CNT_W = 2;

    logic       clk;
    logic       clear;
    logic [1:0] fsm_state;

    branch_sequencer_if #(.CNT_W(CNT_W)) bus ();

    branch_sequencer #(.CNT_W(CNT_W)) dut (
        .clock     (clk),
        .clear     (clear),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    int          m_age = 0;        // cycles since the branch was accepted, 0 = none
    logic        m_taken = 0;
    logic [31:0] m_target = 0;
    logic        e_con = 0;
    logic        e_pc_load = 0;
    logic [31:0] e_pc_next = 0;
    logic        e_done = 0;
    int          e_count = 0;
    logic [31:0] exp_q[$];         // targets expected to be loaded into the PC

    function automatic logic branch_taken(input logic [1:0] c2, input logic [31:0] ra);
        case (c2)
            2'd0:    return ra == 0;
            2'd1:    return ra != 0;
            2'd2:    return ra < 32'h8000_0000;
            default: return ra >= 32'h8000_0000;
        endcase
    endfunction

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            m_age = 0; e_con = 0; e_pc_load = 0; e_pc_next = 0; e_done = 0; e_count = 0;
        end else begin
            if (m_age == 3 && e_pc_load && !bus.abort && e_count < (1 << CNT_W) - 1)
                e_count = e_count + 1;
            e_pc_load = 0;
            e_done    = 0;
            if (bus.abort) begin
                m_age = 0;
            end else if (m_age == 0) begin
                if (bus.start) begin
                    m_taken  = branch_taken(bus.ir[20:19], bus.ra_value);
                    m_target = bus.pc + 32'($signed(bus.ir[18:0]));
                    m_age    = 1;
                end
            end else if (m_age == 1) begin
                e_con = m_taken;
                m_age = 2;
            end else if (m_age == 2) begin
                e_pc_load = m_taken;
                e_done    = 1;
                if (m_taken) begin
                    e_pc_next = m_target;
                    exp_q.push_back(m_target);
                end
                m_age = 3;
            end else begin
                m_age = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("con", 32'(bus.con), 32'(e_con));
        check("pc_load", 32'(bus.pc_load), 32'(e_pc_load));
        check("pc_next", bus.pc_next, e_pc_next);
        check("busy", 32'(bus.busy), 32'(m_age != 0));
        check("done", 32'(bus.done), 32'(e_done));
        check("taken_count", 32'(bus.taken_count), 32'(e_count));
        if (bus.pc_load) begin
            if (exp_q.size() == 0) check("unexpected_pc_load", 32'd1, 32'd0);
            else check("pc_load_target", bus.pc_next, exp_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [1:0] c2, input logic [18:0] c);
        return {11'd0, c2, c};
    endfunction

    task automatic set_op(input logic [1:0] c2, input logic [18:0] c,
                          input logic [31:0] ra, input logic [31:0] p);
        bus.ir       = mk_ir(c2, c);
        bus.ra_value = ra;
        bus.pc       = p;
    endtask

    // start pulse sampled at the next edge; returns just after cycle N+1 begins
    task automatic issue(input logic [1:0] c2, input logic [18:0] c,
                         input logic [31:0] ra, input logic [31:0] p);
        set_op(c2, c, ra, p);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    int dones;

    initial begin
        clear = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.ir = '0; bus.ra_value = '0; bus.pc = '0;
        #3;
        check("reset_con", 32'(bus.con), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_pc_next", bus.pc_next, 32'd0);
        check("reset_count", 32'(bus.taken_count), 32'd0);
        clear = 1'b0;
        tick();

        // taken on ra==0, target 0x110
        issue(2'd0, 19'h00010, 32'd0, 32'h100);
        tick();
        check("t1_con", 32'(bus.con), 32'd1);
        check("t1_pc_load_early", 32'(bus.pc_load), 32'd0);
        tick();
        check("t1_pc_load", 32'(bus.pc_load), 32'd1);
        check("t1_pc_next", bus.pc_next, 32'h110);
        check("t1_done", 32'(bus.done), 32'd1);
        tick();
        check("t1_count", 32'(bus.taken_count), 32'd1);
        check("t1_idle", 32'(bus.busy), 32'd0);

        // not taken: ra==0 fails ra!=0
        issue(2'd1, 19'h00040, 32'd0, 32'h200);
        tick();
        tick();
        check("t2_con", 32'(bus.con), 32'd0);
        check("t2_pc_load", 32'(bus.pc_load), 32'd0);
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_pc_next_hold", bus.pc_next, 32'h110);
        tick();
        check("t2_count", 32'(bus.taken_count), 32'd1);

        // negative displacement wraps below zero
        issue(2'd3, 19'h7FFF8, 32'h8000_0000, 32'h4);
        tick();
        tick();
        check("t3_pc_load", 32'(bus.pc_load), 32'd1);
        check("t3_pc_next", bus.pc_next, 32'hFFFF_FFFC);
        tick();
        check("t3_count", 32'(bus.taken_count), 32'd2);

        // second start while busy is ignored
        set_op(2'd2, 19'h00020, 32'h7FFF_FFFF, 32'h1000);
        bus.start = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            dones += int'(bus.done);
            tick();
        end
        check("t4_single_done", 32'(dones), 32'd1);
        check("t4_count", 32'(bus.taken_count), 32'd3);

        // abort in RESOLVE: con keeps the captured value, no commit
        issue(2'd0, 19'h00008, 32'd5, 32'h300);
        tick();
        check("t5_con_captured", 32'(bus.con), 32'd0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_idle", 32'(bus.busy), 32'd0);
        check("t5_no_done", 32'(bus.done), 32'd0);
        check("t5_no_pc_load", 32'(bus.pc_load), 32'd0);
        check("t5_con_hold", 32'(bus.con), 32'd0);
        tick();
        check("t5_still_idle", 32'(bus.done), 32'd0);

        // abort beats start in IDLE
        set_op(2'd0, 19'h00004, 32'd0, 32'h400);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("t6_abort_wins", 32'(bus.busy), 32'd0);
        tick();

        // fresh counter, five taken branches saturate a 2-bit count
        clear = 1'b1;
        #2;
        clear = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            issue(2'd1, 19'(k * 4), 32'd7, 32'h500 + 32'(k) * 32'h10);
            tick();
            tick();
            tick();
        end
        check("t7_saturated", 32'(bus.taken_count), 32'd3);

        // clear in RESOLVE zeroes everything immediately
        issue(2'd0, 19'h00100, 32'd0, 32'h600);
        tick();
        #2;
        clear = 1'b1;
        #1;
        check("t8_con_clr", 32'(bus.con), 32'd0);
        check("t8_busy_clr", 32'(bus.busy), 32'd0);
        check("t8_pc_next_clr", bus.pc_next, 32'd0);
        check("t8_count_clr", 32'(bus.taken_count), 32'd0);
        check("t8_done_clr", 32'(bus.done), 32'd0);
        @(negedge clk);
        #1;
        clear = 1'b0;
        set_op(2'd1, 19'h00002, 32'd1, 32'h700);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t8_start_after_clear", 32'(bus.busy), 32'd1);
        tick();
        tick();
        check("t8_pc_load", 32'(bus.pc_load), 32'd1);
        check("t8_pc_next", bus.pc_next, 32'h702);
        tick();
        tick();
        check("t8_count", 32'(bus.taken_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the taken-branch counter.
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port clear  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse; branch instruction is decoded and operands are valid this cycle.
REQ-005 SHALL have port abort  input  1  flush request; cancels any in-flight branch.
REQ-006 SHALL have port ir  input  32  instruction word; C2 = ir[20:19], displacement C = ir[18:0].
REQ-007 SHALL have port ra_value  input  32  contents of register Ra.
REQ-008 SHALL have port pc  input  32  already-incremented program counter.
REQ-009 SHALL have port con  output  1  registered CON flip-flop (branch-taken flag).
REQ-010 SHALL have port pc_load  output  1  one-cycle write strobe to PC.
REQ-011 SHALL have port pc_next  output  32  branch target presented with pc_load.
REQ-012 SHALL have port busy  output  1  high in any non-IDLE state.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port taken_count  output  CNT_W  count of taken branches.

Function
REQ-015 SHALL implement states IDLE, CAPTURE, RESOLVE and COMMIT, one clock each.
REQ-016 In IDLE, start=1 SHALL latch ir[20:0], ra_value and pc into internal registers and move to CAPTURE.
REQ-017 start SHALL be ignored while busy=1; no queuing.
REQ-018 In CAPTURE, the block SHALL evaluate the condition from the latched values: C2=0 -> ra==0; C2=1 -> ra!=0; C2=2 -> ra[31]==0; C2=3 -> ra[31]==1.
REQ-019 The condition result SHALL be written into con on the CAPTURE->RESOLVE edge.
REQ-020 con SHALL hold its value until the next CAPTURE or reset.
REQ-021 In RESOLVE, the target SHALL be computed as latched_pc + sign-extended 19-bit C, modulo 2^32 (wrap-around, no overflow flag); the result is registered into pc_next.
REQ-022 On the RESOLVE->COMMIT edge, pc_load SHALL be set equal to con.
REQ-023 In COMMIT, done SHALL be 1 for exactly one cycle; the next state is IDLE.
REQ-024 Latency: start at cycle N SHALL give pc_load/done at cycle N+3, with con visible from N+2.
REQ-025 pc_next SHALL hold its last value when pc_load=0; consumers SHALL qualify it with pc_load.
REQ-026 taken_count SHALL increment by 1 in each COMMIT cycle with pc_load=1, and SHALL saturate at all-ones without wrapping.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge, suppressing pc_load, done and the count increment; con and pc_next keep their values.
REQ-028 If abort and start are asserted together in IDLE, abort SHALL win and the state remains IDLE.
REQ-029 Outputs pc_load and done SHALL never be asserted outside COMMIT.

Reset
REQ-030 clear=1 SHALL asynchronously force state IDLE, con=0, pc_load=0, pc_next=0, busy=0, done=0 and taken_count=0, regardless of clock.
REQ-031 clear asserted mid-operation SHALL discard the in-flight branch; no pc_load SHALL follow the deassertion of clear.
REQ-032 After clear deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-033 Bench: C2=0, ra=0, pc=0x100, C=0x00010, start -> con=1 at N+2; pc_load=1 and pc_next=0x110 at N+3; taken_count=1.
REQ-034 Bench: C2=1, ra=0, pc=0x200, start -> con=0, pc_load=0, done=1 at N+3, taken_count unchanged.
REQ-035 Bench: C2=3, ra=0x80000000, pc=0x00000004, C=0x7FFF8 (-8) -> pc_load=1, pc_next=0xFFFFFFFC (wrap-around).
REQ-036 Bench: C2=2, ra=0x7FFFFFFF, start; second start at N+1 -> only one done; the second start is ignored.
REQ-037 Bench: start, then abort at N+2 -> state IDLE at N+3, no pc_load and no done; con retains the value captured at N+2.
REQ-038 Bench: CNT_W=2, five taken branches -> taken_count saturates at 3; clear pulse mid-RESOLVE -> all outputs 0 immediately.
